// File: rtl/sequential_to_simultaneous_reg.sv
`default_nettype none
// ============================================================================
// Module   : sequential_to_simultaneous_reg
// Purpose  : Serial-to-parallel frame collector for the BCH decoder datapath.
//            Packs SHIFT_LEN paced words of BIT_WIDTH bits into one parallel
//            bus, then holds it with a valid level and a one-cycle done pulse.
// Ports    : clk            - clock, rising edge
//            in_ctr_Srst    - synchronous active-high reset (highest priority)
//            in_ctr_init    - start a new frame (clears bus and counters)
//            in_ctr_en      - global enable; state holds when low
//            in_ctr_sft_en  - input-word qualifier
//            in             - serial input word
//            out            - packed frame, slot k = out[BW*(k+1)-1 : BW*k]
//            out_valid      - high while the frame is complete (FULL)
//            out_done       - one-cycle pulse on entry to FULL
//            out_cnt        - words captured in the current frame
//            out_ovf        - sticky overflow flag (optional)
// Options  : SEQ_TO_SIM_REG_OVF_FLAG_EN adds out_ovf, set when a qualified
//            word arrives while FULL; cleared by reset or init.
// Revision : 1.0 - initial release
// ============================================================================
module sequential_to_simultaneous_reg #(
  parameter int DIRECTION    = 1,
  parameter int SHIFT_LEN    = 4,
  parameter int BIT_WIDTH    = 2,
  parameter int CLK_DISTANCE = 1
) (
  input  logic                            clk,
  input  logic                            in_ctr_Srst,
  input  logic                            in_ctr_init,
  input  logic                            in_ctr_en,
  input  logic                            in_ctr_sft_en,
  input  logic [BIT_WIDTH-1:0]            in,
  output logic [BIT_WIDTH*SHIFT_LEN-1:0]  out,
  output logic                            out_valid,
  output logic                            out_done,
  output logic [$clog2(SHIFT_LEN):0]      out_cnt
`ifdef SEQ_TO_SIM_REG_OVF_FLAG_EN
  ,
  output logic                            out_ovf
`endif
);

  localparam int TOTAL_W  = BIT_WIDTH * SHIFT_LEN;
  localparam int CNT_W    = $clog2(SHIFT_LEN) + 1;
  // A distance of 0 behaves like 1, i.e. the pace counter never leaves 0.
  localparam int PACE_MAX = (CLK_DISTANCE <= 1) ? 0 : CLK_DISTANCE - 1;
  localparam int PACE_W   = (PACE_MAX > 0) ? $clog2(PACE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t              state_q;
  logic [TOTAL_W-1:0]  data_q;
  logic [TOTAL_W-1:0]  data_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [PACE_W-1:0]   pace_q;
  logic [PACE_W-1:0]   pace_d;
  logic                done_q;
  logic                ovf_q;
  logic                qual_w;
  logic                capture_w;
  logic                last_w;

  // Shifted register contents with the new word inserted.
  generate
    if (SHIFT_LEN == 1) begin : g_single
      assign data_d = in;
    end else if (DIRECTION != 0) begin : g_shift_down
      // New word enters the top slot; the first word ends up in slot 0.
      assign data_d = {in, data_q[TOTAL_W-1:BIT_WIDTH]};
    end else begin : g_shift_up
      // New word enters slot 0; the first word ends up in the top slot.
      assign data_d = {data_q[TOTAL_W-BIT_WIDTH-1:0], in};
    end
  endgenerate

  // Qualified cycles only count while collecting; init takes precedence
  // in the sequential block, so it is not repeated here.
  assign qual_w    = (state_q == ST_COLLECT) && in_ctr_sft_en;
  assign capture_w = qual_w && (pace_q == '0);
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign last_w    = (cnt_d == CNT_W'(SHIFT_LEN));
  assign pace_d    = (pace_q == PACE_W'(PACE_MAX)) ? '0 : pace_q + PACE_W'(1);

  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      pace_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // Done is a pulse: it falls after one cycle even when disabled.
      done_q <= 1'b0;
      if (in_ctr_en) begin
        if (in_ctr_init) begin
          state_q <= ST_COLLECT;
          data_q  <= '0;
          cnt_q   <= '0;
          pace_q  <= '0;
          ovf_q   <= 1'b0;
        end else if (qual_w) begin
          pace_q <= pace_d;
          if (capture_w) begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            if (last_w) begin
              state_q <= ST_FULL;
              done_q  <= 1'b1;
            end
          end
        end else if ((state_q == ST_FULL) && in_ctr_sft_en) begin
          // Word is dropped; only the overflow flag records it.
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign out       = data_q;
  assign out_valid = (state_q == ST_FULL);
  assign out_done  = done_q;
  assign out_cnt   = cnt_q;

`ifdef SEQ_TO_SIM_REG_OVF_FLAG_EN
  assign out_ovf = ovf_q;
`else
  logic unused_ovf_w;
  assign unused_ovf_w = ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/sequential_to_simultaneous_reg.md
Name: sequential_to_simultaneous_reg

Overview:
Serial-to-parallel collector and the downstream counterpart of the parallel-to-serial shift stage in the BCH decoder datapath. It accepts one BIT_WIDTH word per paced sample and packs SHIFT_LEN words into one parallel bus. When the frame is complete it holds the bus, raises a valid level and emits a one-cycle done pulse. It feeds the next decoder stage, for example a syndrome or locator block that needs all words at once.

Parameters:
DIRECTION, 1, fill order. 1: each new word enters the top slot and shifts toward slot 0, so the first word ends in slot 0. 0: each new word enters slot 0 and shifts up, so the first word ends in the top slot.
SHIFT_LEN, 4, number of words per frame. Must be ≥1.
BIT_WIDTH, 2, bits per word.
CLK_DISTANCE, 1, sampling pace in qualified cycles. A value of 0 is treated as 1.

Ports:
clk  input  1  clock; all state changes on the rising edge
in_ctr_Srst  input  1  synchronous active-high reset; highest priority
in_ctr_init  input  1  starts a new frame
in_ctr_en  input  1  global enable; when low, all state holds except out_done
in_ctr_sft_en  input  1  input-word qualifier
in  input  BIT_WIDTH  serial input word
out  output  BIT_WIDTH*SHIFT_LEN  packed frame; slot k = out[BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k]
out_valid  output  1  high while state is FULL
out_done  output  1  one-cycle pulse on entry to FULL
out_cnt  output  clog2(SHIFT_LEN)+1  words captured in the current frame

Behaviour:
- Reset (in_ctr_Srst=1 at an edge): out=0, out_valid=0, out_done=0, out_cnt=0, pace counter=0, state=IDLE. Reset overrides in_ctr_en and in_ctr_init.
- Priority: Srst > en > init > capture. Every item below requires in_ctr_en=1 unless stated.
- State IDLE:
  - No captures; in_ctr_sft_en is ignored.
  - init → COLLECT.
- init, in any state: out=0, out_cnt=0, pace counter=0, next state COLLECT. The word present in the init cycle is not captured.
- Pacing, in COLLECT only:
  - A qualified cycle is one with in_ctr_sft_en=1 and no init.
  - A capture occurs on a qualified cycle when the pace counter is 0.
  - Every qualified cycle advances the pace counter modulo CLK_DISTANCE.
  - CLK_DISTANCE=1 captures every qualified cycle.
  - CLK_DISTANCE=3 captures qualified cycles 1, 4, 7, …
- Capture:
  - The register shifts by one slot per DIRECTION and the new word is inserted.
  - out_cnt increments by 1.
  - The capture that makes out_cnt == SHIFT_LEN moves the state to COLLECT → FULL in the same edge.
  - out_valid=1 and the final out value are visible after that edge, i.e. one cycle after the last word is presented.
  - out_done=1 for exactly one clk cycle, aligned with the first cycle of out_valid.
- State FULL:
  - out, out_cnt and out_valid hold.
  - Further in_ctr_sft_en is ignored, and the word is dropped.
  - init → COLLECT, which clears out and drops out_valid after that edge.
- in_ctr_en=0:
  - State, counters and out hold.
  - out_done still deasserts after one cycle; it is never stretched.
  - A capture pending in a disabled cycle is lost, not deferred.
- Reset mid-frame: partial data is discarded and the block returns to IDLE. A new init is needed before any capture.
- SHIFT_LEN=1: the first capture goes directly to FULL, with out=in.

Optional Feature:
Macro SEQ_TO_SIM_REG_OVF_FLAG_EN.
- Defined:
  - Adds output out_ovf (1 bit, sticky), reset value 0.
  - out_ovf is set at the edge of any cycle in FULL with in_ctr_en=1, in_ctr_sft_en=1 and in_ctr_init=0. Pacing is not applied.
  - out_ovf is cleared by in_ctr_Srst or init.
- Undefined: the port is absent and words arriving in FULL are dropped silently.

Test Plan:
- SHIFT_LEN=4, BIT_WIDTH=2, DIRECTION=1, CLK_DISTANCE=1: init, then words 1,2,3,0 on consecutive sft_en cycles → out=8'h39; out_valid and out_done rise one cycle after word 0; out_done is high 1 cycle; out_cnt=4.
- Same stimulus with DIRECTION=0 → out=8'h6C.
- DIRECTION=1, CLK_DISTANCE=2: sft_en held high with words 1,2,3,0,1,2,3,0 → captures 1,3,1,3; out=8'hDD; out_valid rises after the 7th word.
- Reset mid-frame after 2 captures → out=0, out_cnt=0, out_valid=0. Subsequent sft_en with words 1,1,1,1 and no init → no change.
- In FULL (out=8'h39), init and sft_en with word 2 in the same cycle → out=0, out_cnt=0, out_valid=0; word 2 is not captured. With OVF_FLAG_EN, a prior extra sft_en in FULL sets out_ovf=1, and this init clears it.
- in_ctr_en low for 3 cycles after 2 captures, sft_en high throughout → out_cnt stays 2 and out is unchanged. Re-enable and supply 2 more words → FULL, with out_done pulsing once.
